wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/kgp_pkg.sv | 24 ++
 rtl/wb_data_mux.sv | 30 +++
 rtl/wb_stage.sv | 101 ++++++++++
 tb/tb_wb_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// kgp_pkg -- definitions shared by the write-back stage and its data mux.
//   wb_sel_t   : write-back source select (ALU, MEM, LINK, NONE)
//   wb_state_t : write-back sequencing state (IDLE, WAIT_MEM)
//   is_load    : true when an accepted instruction must wait for load data
package kgp_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_NONE = 2'b11
    } wb_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    // A MEM-sourced instruction only waits for load data if it writes a register.
    function automatic logic is_load(input wb_sel_t sel, input logic reg_write);
        return reg_write && (sel == WB_SEL_MEM);
    endfunction

endpackage

// File: rtl/wb_data_mux.sv
// wb_data_mux -- combinational write-back source selection.
//   sel  : write-back source select
//   alu  : ALU result
//   mem  : load data
//   link : pc+4 link value
//   data : selected write data (zero for NONE)
module wb_data_mux
    import kgp_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wb_sel_t           sel,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] mem,
    input  logic [DATA_W-1:0] link,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        // NOTE: default assignment first so every path drives data (no latch).
        data = '0;
        unique case (sel)
            WB_SEL_ALU:  data = alu;
            WB_SEL_MEM:  data = mem;
            WB_SEL_LINK: data = link;
            WB_SEL_NONE: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage -- pipeline write-back stage with load-wait sequencing.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid / in_ready        : instruction offer / accept handshake
//   alu_result, pc_plus4       : ALU and link write-back sources
//   wb_sel, reg_write, rd      : write-back select, write enable, destination
//   mem_rdata, mem_rvalid      : load data and its single-cycle qualifier
//   rf_we, rf_waddr, rf_wdata  : register-file write port (one-cycle strobe)
//   busy                       : a load is outstanding
//   retired                    : wrapping count of committed instructions
module wb_stage
    import kgp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        wb_sel,
    input  logic              reg_write,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  retired
);

    wb_state_t         state;
    wb_sel_t           sel_in;
    wb_sel_t           mux_sel;
    logic [DATA_W-1:0] mux_data;
    logic [4:0]        load_rd;
    logic              accept;

    assign sel_in   = wb_sel_t'(wb_sel);
    assign in_ready = (state != WAIT_MEM);
    assign busy     = (state == WAIT_MEM);
    assign accept   = in_valid && in_ready;

    // While waiting, the only possible write source is the returning load data.
    assign mux_sel = (state == WAIT_MEM) ? WB_SEL_MEM : sel_in;

    wb_data_mux #(.DATA_W(DATA_W)) u_mux (
        .sel  (mux_sel),
        .alu  (alu_result),
        .mem  (mem_rdata),
        .link (pc_plus4),
        .data (mux_data)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            retired  <= '0;
            load_rd  <= '0;
        end else begin
            // rf_we is a one-cycle strobe; address and data hold between writes.
            rf_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load(sel_in, reg_write)) begin
                            load_rd <= rd;
                            state   <= WAIT_MEM;
                        end else begin
                            retired <= retired + CNT_W'(1);
                            // x0 is hard-wired: the write is dropped but still retires.
                            if (reg_write && sel_in != WB_SEL_NONE && rd != 5'd0) begin
                                rf_we    <= 1'b1;
                                rf_waddr <= rd;
                                rf_wdata <= mux_data;
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state   <= IDLE;
                        retired <= retired + CNT_W'(1);
                        if (load_rd != 5'd0) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= load_rd;
                            rf_wdata <= mux_data;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- self-checking bench for wb_stage.
// A transaction-level model tracks the outstanding load and commits; a compare
// process checks every DUT output against it on each falling edge, and the
// directed sequence adds literal expectations that pin the model.
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc_plus4;
    logic [1:0]        wb_sel;
    logic              reg_write;
    logic [4:0]        rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;
    logic [CNT_W-1:0]  retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .pc_plus4   (pc_plus4),
        .wb_sel     (wb_sel),
        .reg_write  (reg_write),
        .rd         (rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .retired    (retired)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit              model_live = 1'b0;
    bit              m_wait     = 1'b0;
    int              m_rd       = 0;
    bit              exp_we     = 1'b0;
    int              exp_addr   = 0;
    logic [31:0]     exp_data   = '0;
    int              exp_ret    = 0;

    function automatic void commit(input int dest, input logic [31:0] value);
        exp_ret = (exp_ret + 1) % (1 << CNT_W);
        if (dest != 0) begin
            exp_we   = 1'b1;
            exp_addr = dest;
            exp_data = value;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_live = 1'b1;
            m_wait     = 1'b0;
            exp_we     = 1'b0;
            exp_addr   = 0;
            exp_data   = '0;
            exp_ret    = 0;
        end else begin
            exp_we = 1'b0;
            if (m_wait) begin
                if (mem_rvalid) begin
                    m_wait = 1'b0;
                    commit(m_rd, mem_rdata);
                end
            end else if (in_valid) begin
                if (reg_write && wb_sel == 2'd1) begin
                    m_wait = 1'b1;
                    m_rd   = int'(rd);
                end else if (reg_write && wb_sel == 2'd0) begin
                    commit(int'(rd), alu_result);
                end else if (reg_write && wb_sel == 2'd2) begin
                    commit(int'(rd), pc_plus4);
                end else begin
                    commit(0, '0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("in_ready", 64'(in_ready), 64'(!m_wait));
            check("busy",     64'(busy),     64'(m_wait));
            check("rf_we",    64'(rf_we),    64'(exp_we));
            check("rf_waddr", 64'(rf_waddr), 64'(exp_addr));
            check("rf_wdata", 64'(rf_wdata), 64'(exp_data));
            check("retired",  64'(retired),  64'(exp_ret));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic v, input logic [1:0] sel, input logic rw,
                          input logic [4:0] dest, input logic [31:0] alu,
                          input logic [31:0] link);
        in_valid   = v;
        wb_sel     = sel;
        reg_write  = rw;
        rd         = dest;
        alu_result = alu;
        pc_plus4   = link;
    endtask

    task automatic idle();
        set_in(1'b0, 2'd0, 1'b0, 5'd0, '0, '0);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("lit_reset_in_ready", 64'(in_ready), 64'd1);
        check("lit_reset_rf_we",    64'(rf_we),    64'd0);
        check("lit_reset_retired",  64'(retired),  64'd0);
        check("lit_reset_wdata",    64'(rf_wdata), 64'd0);

        // ALU write
        set_in(1'b1, 2'b00, 1'b1, 5'd5, 32'h0000_00AB, 32'h0);
        @(negedge clk);
        idle();
        check("lit_alu_we",      64'(rf_we),    64'd1);
        check("lit_alu_waddr",   64'(rf_waddr), 64'd5);
        check("lit_alu_wdata",   64'(rf_wdata), 64'hAB);
        check("lit_alu_retired", 64'(retired),  64'd1);
        @(negedge clk);
        check("lit_alu_hold_we",   64'(rf_we),    64'd0);
        check("lit_alu_hold_data", 64'(rf_wdata), 64'hAB);

        // Load, returning 3 cycles after accept; offers during the wait are refused
        set_in(1'b1, 2'b01, 1'b1, 5'd9, 32'h0, 32'h0);
        @(negedge clk);
        set_in(1'b1, 2'b00, 1'b1, 5'd3, 32'h33, 32'h0);
        check("lit_load_busy",     64'(busy),     64'd1);
        check("lit_load_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        set_in(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("lit_load_we",    64'(rf_we),    64'd1);
        check("lit_load_waddr", 64'(rf_waddr), 64'd9);
        check("lit_load_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        check("lit_load_ret",   64'(retired),  64'd2);

        // Back-to-back LINK then ALU, starting the cycle the load write shows
        set_in(1'b1, 2'b10, 1'b1, 5'd31, 32'h0, 32'h104);
        @(negedge clk);
        set_in(1'b1, 2'b00, 1'b1, 5'd2, 32'd7, 32'h0);
        check("lit_b2b_we0",   64'(rf_we),    64'd1);
        check("lit_b2b_addr0", 64'(rf_waddr), 64'd31);
        check("lit_b2b_data0", 64'(rf_wdata), 64'h104);
        @(negedge clk);
        idle();
        check("lit_b2b_we1",   64'(rf_we),    64'd1);
        check("lit_b2b_addr1", 64'(rf_waddr), 64'd2);
        check("lit_b2b_data1", 64'(rf_wdata), 64'd7);
        check("lit_b2b_ret",   64'(retired),  64'd4);

        // Suppression: rd=0 ALU, NONE, reg_write=0; stray mem_rvalid in IDLE
        set_in(1'b1, 2'b00, 1'b1, 5'd0, 32'h55, 32'h0);
        @(negedge clk);
        check("lit_sup_rd0_we", 64'(rf_we), 64'd0);
        set_in(1'b1, 2'b11, 1'b1, 5'd4, 32'h99, 32'h0);
        @(negedge clk);
        check("lit_sup_none_we", 64'(rf_we),    64'd0);
        check("lit_sup_ret",     64'(retired),  64'd6);
        check("lit_sup_hold",    64'(rf_wdata), 64'd7);
        set_in(1'b1, 2'b00, 1'b0, 5'd8, 32'h77, 32'h0);
        @(negedge clk);
        idle();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_0001;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("lit_rw0_ret",     64'(retired), 64'd7);
        check("lit_idle_rvalid", 64'(rf_we),   64'd0);

        // Reset mid-load, with a simultaneous accept offered during reset
        set_in(1'b1, 2'b01, 1'b1, 5'd12, 32'h0, 32'h0);
        @(negedge clk);
        check("lit_rl_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        set_in(1'b1, 2'b00, 1'b1, 5'd6, 32'h66, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("lit_rl_busy0",  64'(busy),     64'd0);
        check("lit_rl_ret0",   64'(retired),  64'd0);
        check("lit_rl_data0",  64'(rf_wdata), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("lit_rl_we",  64'(rf_we),   64'd0);
        check("lit_rl_ret", 64'(retired), 64'd0);

        // Wrap: 65535 back-to-back NONE commits, then one ALU commit
        set_in(1'b1, 2'b11, 1'b1, 5'd0, 32'h0, 32'h0);
        repeat (65535) @(negedge clk);
        check("lit_wrap_pre", 64'(retired), 64'hFFFF);
        set_in(1'b1, 2'b00, 1'b1, 5'd1, 32'h1, 32'h0);
        @(negedge clk);
        idle();
        check("lit_wrap_ret", 64'(retired), 64'h0);
        check("lit_wrap_we",  64'(rf_we),   64'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
